// File: rtl/clint_pkg.sv
// Core-local interruptor shared definitions.
// Register offsets, reset constants and byte-lane merge helper.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler plus 64-bit mtime counter.
// Bus writes to either half override the tick for that cycle.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [63:0] mtime_o
);

  logic        tick;
  logic [63:0] mtime_q, mtime_d;

  generate
    if (TICK_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(TICK_DIV);
      localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
      logic [CW-1:0] cnt_q, cnt_d;

      assign tick = (cnt_q == LAST);

      // Prescaler wraps after TICK_DIV cycles
      always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
      end

      // Prescaler register
      always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Write to a half wins; otherwise count on tick
  always_comb begin
    mtime_d = mtime_q;
    if (wr_lo_i) begin
      mtime_d[31:0] = be_merge(mtime_q[31:0], wdata_i, be_i);
    end else if (wr_hi_i) begin
      mtime_d[63:32] = be_merge(mtime_q[63:32], wdata_i, be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtime register
  always_ff @(posedge clk_i) begin
    if (rst_i) mtime_q <= '0;
    else       mtime_q <= mtime_d;
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor top: decode, readback, mtimecmp/msip.
// Drives registered software and timer interrupt lines.
module clint
  import clint_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [31:0]       bus_writedata,
  input  logic [3:0]        bus_byteenable,
  output logic [31:0]       bus_readdata,
  output logic              bus_readdatavalid,
  output logic              software_interrupt,
  output logic              timer_interrupt
);

  logic [ADDR_W-1:0] word_addr;
  logic              hit_msip, hit_cmp_lo, hit_cmp_hi;
  logic              hit_mt_lo, hit_mt_hi;
  logic [63:0]       mtime;
  logic              msip_q, msip_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic [31:0]       rdata_q, rdata_d, rmux;
  logic              rvalid_q, sw_q, ti_q;

  assign word_addr  = bus_address & ~ADDR_W'(3);
  assign hit_msip   = (word_addr == ADDR_W'(CLINT_MSIP));
  assign hit_cmp_lo = (word_addr == ADDR_W'(CLINT_MTIMECMP_LO));
  assign hit_cmp_hi = (word_addr == ADDR_W'(CLINT_MTIMECMP_HI));
  assign hit_mt_lo  = (word_addr == ADDR_W'(CLINT_MTIME_LO));
  assign hit_mt_hi  = (word_addr == ADDR_W'(CLINT_MTIME_HI));

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .wr_lo_i(bus_write & hit_mt_lo),
    .wr_hi_i(bus_write & hit_mt_hi),
    .wdata_i(bus_writedata),
    .be_i   (bus_byteenable),
    .mtime_o(mtime)
  );

  // Readback from registered state, so read+write sees old data
  always_comb begin
    rmux = '0;
    unique case (1'b1)
      hit_msip:   rmux = {31'b0, msip_q};
      hit_cmp_lo: rmux = mtimecmp_q[31:0];
      hit_cmp_hi: rmux = mtimecmp_q[63:32];
      hit_mt_lo:  rmux = mtime[31:0];
      hit_mt_hi:  rmux = mtime[63:32];
      default:    rmux = '0;
    endcase
  end

  // Next state for msip, mtimecmp and read data holding
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = bus_read ? rmux : rdata_q;
    if (bus_write && hit_msip && bus_byteenable[0]) begin
      msip_d = bus_writedata[0];
    end
    if (bus_write && hit_cmp_lo) begin
      mtimecmp_d[31:0] =
        be_merge(mtimecmp_q[31:0], bus_writedata, bus_byteenable);
    end
    if (bus_write && hit_cmp_hi) begin
      mtimecmp_d[63:32] =
        be_merge(mtimecmp_q[63:32], bus_writedata, bus_byteenable);
    end
  end

  // State and registered interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= CLINT_MTIMECMP_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      sw_q       <= 1'b0;
      ti_q       <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= bus_read;
      sw_q       <= msip_q;
      ti_q       <= (mtime >= mtimecmp_q);
    end
  end

  assign bus_readdata       = rdata_q;
  assign bus_readdatavalid  = rvalid_q;
  assign software_interrupt = sw_q;
  assign timer_interrupt    = ti_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint (TICK_DIV=1 and TICK_DIV=4).
// Random and directed bus traffic against a behavioural model.
module tb_clint;
  import clint_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        sel = 1'b0;
  logic        b_read = 1'b0, b_write = 1'b0;
  logic [15:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_be = '0;

  logic        rq0, wq0, rq1, wq1;
  logic [31:0] rd0, rd1;
  logic        rv0, rv1, sw0, sw1, ti0, ti1;
  logic [31:0] obs_rd;
  logic        obs_rv, obs_sw, obs_ti;

  assign rq0 = b_read  & ~sel;
  assign wq0 = b_write & ~sel;
  assign rq1 = b_read  &  sel;
  assign wq1 = b_write &  sel;
  assign obs_rd = sel ? rd1 : rd0;
  assign obs_rv = sel ? rv1 : rv0;
  assign obs_sw = sel ? sw1 : sw0;
  assign obs_ti = sel ? ti1 : ti0;

  clint #(.ADDR_W(16), .TICK_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .bus_read(rq0), .bus_write(wq0),
    .bus_address(b_addr), .bus_writedata(b_wdata),
    .bus_byteenable(b_be),
    .bus_readdata(rd0), .bus_readdatavalid(rv0),
    .software_interrupt(sw0), .timer_interrupt(ti0)
  );

  clint #(.ADDR_W(16), .TICK_DIV(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .bus_read(rq1), .bus_write(wq1),
    .bus_address(b_addr), .bus_writedata(b_wdata),
    .bus_byteenable(b_be),
    .bus_readdata(rd1), .bus_readdatavalid(rv1),
    .software_interrupt(sw1), .timer_interrupt(ti1)
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_mt [2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  logic        m_ti[2];
  logic        m_sw[2];
  int unsigned m_k[2];

  function automatic int unsigned td(input int s);
    return (s == 1) ? 4 : 1;
  endfunction

  function automatic logic [31:0] lane(input logic [31:0] o,
                                       input logic [31:0] n,
                                       input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [63:0] nx_mt(input int s);
    logic [63:0] v;
    logic        we;
    logic [15:0] wa;
    v  = m_mt[s];
    we = b_write && (int'(sel) == s);
    wa = b_addr & 16'hFFFC;
    if (we && wa == CLINT_MTIME_LO)
      v[31:0] = lane(v[31:0], b_wdata, b_be);
    else if (we && wa == CLINT_MTIME_HI)
      v[63:32] = lane(v[63:32], b_wdata, b_be);
    else if ((m_k[s] % td(s)) == td(s) - 1)
      v = v + 64'd1;
    return v;
  endfunction

  function automatic logic [63:0] nx_cmp(input int s);
    logic [63:0] v;
    logic        we;
    logic [15:0] wa;
    v  = m_cmp[s];
    we = b_write && (int'(sel) == s);
    wa = b_addr & 16'hFFFC;
    if (we && wa == CLINT_MTIMECMP_LO)
      v[31:0] = lane(v[31:0], b_wdata, b_be);
    if (we && wa == CLINT_MTIMECMP_HI)
      v[63:32] = lane(v[63:32], b_wdata, b_be);
    return v;
  endfunction

  function automatic logic nx_msip(input int s);
    logic we;
    we = b_write && (int'(sel) == s);
    if (we && (b_addr & 16'hFFFC) == CLINT_MSIP && b_be[0])
      return b_wdata[0];
    return m_msip[s];
  endfunction

  function automatic logic [31:0] model_read(input int s,
                                             input logic [15:0] a);
    case (a & 16'hFFFC)
      CLINT_MSIP:        return {31'b0, m_msip[s]};
      CLINT_MTIMECMP_LO: return m_cmp[s][31:0];
      CLINT_MTIMECMP_HI: return m_cmp[s][63:32];
      CLINT_MTIME_LO:    return m_mt[s][31:0];
      CLINT_MTIME_HI:    return m_mt[s][63:32];
      default:           return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_mt[s]   <= '0;
        m_cmp[s]  <= '1;
        m_msip[s] <= 1'b0;
        m_ti[s]   <= 1'b0;
        m_sw[s]   <= 1'b0;
        m_k[s]    <= 0;
      end else begin
        m_mt[s]   <= nx_mt(s);
        m_cmp[s]  <= nx_cmp(s);
        m_msip[s] <= nx_msip(s);
        m_ti[s]   <= (m_mt[s] >= m_cmp[s]);
        m_sw[s]   <= m_msip[s];
        m_k[s]    <= m_k[s] + 1;
      end
    end
  end

  // ---------------- bus drivers ----------------
  task automatic bus_op(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be,
                        output logic [31:0] exp,
                        output logic [31:0] got,
                        output logic gv);
    b_read  = rd;
    b_write = wr;
    b_addr  = a;
    b_wdata = d;
    b_be    = be;
    exp = model_read(int'(sel), a);
    @(negedge clk);
    b_read  = 1'b0;
    b_write = 1'b0;
    got = obs_rd;
    gv  = obs_rv;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    logic [31:0] e, g;
    logic v;
    bus_op(1'b0, 1'b1, a, d, be, e, g, v);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] exp,
                    output logic [31:0] got, output logic gv);
    bus_op(1'b1, 1'b0, a, 32'h0, 4'h0, exp, got, gv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] e, g, v1, v2;
    logic gv;
    sel = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd0, rv0, sw0, ti0} !== 35'h0) begin
      errors++;
      $display("FAIL reset_out0 got %h want 0", {rd0, rv0, sw0, ti0});
    end
    checks++;
    if ({rd1, rv1, sw1, ti1} !== 35'h0) begin
      errors++;
      $display("FAIL reset_out1 got %h want 0", {rd1, rv1, sw1, ti1});
    end
    rst = 1'b0;
    rd(CLINT_MTIMECMP_LO, e, g, gv);
    checks++;
    if (g !== 32'hFFFF_FFFF || gv !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmp_lo got %h/%b want ffffffff/1", g, gv);
    end
    rd(CLINT_MTIMECMP_HI, e, g, gv);
    checks++;
    if (g !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_cmp_hi got %h want ffffffff", g);
    end
    rd(CLINT_MTIME_LO, e, v1, gv);
    checks++;
    if (v1 !== e || v1 > 32'd10) begin
      errors++;
      $display("FAIL reset_mtime got %h want %h", v1, e);
    end
    rd(CLINT_MTIME_LO, e, v2, gv);
    checks++;
    if (v2 !== v1 + 32'd1) begin
      errors++;
      $display("FAIL reset_mtime_inc got %h want %h", v2, v1 + 32'd1);
    end
    checks++;
    if (ti0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ti got %b want 0", ti0);
    end
  endtask

  task automatic test_timer_cmp();
    logic prev;
    logic [63:0] rise_mt;
    bit seen;
    sel = 1'b0;
    do_reset();
    wr(CLINT_MTIMECMP_HI, 32'h0, 4'hF);
    wr(CLINT_MTIMECMP_LO, 32'h20, 4'hF);
    prev = obs_ti;
    seen = 0;
    rise_mt = '0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (obs_ti !== m_ti[0]) begin
        errors++;
        $display("FAIL cmp_ti got %b want %b", obs_ti, m_ti[0]);
      end
      if (obs_ti && !prev) begin
        seen = 1;
        rise_mt = m_mt[0];
      end
      prev = obs_ti;
    end
    checks++;
    if (!seen || rise_mt !== 64'h21) begin
      errors++;
      $display("FAIL cmp_rise seen %0d mtime %h want 21", seen, rise_mt);
    end
    wr(CLINT_MTIMECMP_HI, 32'h1, 4'hF);
    checks++;
    if (obs_ti !== 1'b1) begin
      errors++;
      $display("FAIL cmp_hold got %b want 1", obs_ti);
    end
    @(negedge clk);
    checks++;
    if (obs_ti !== 1'b0) begin
      errors++;
      $display("FAIL cmp_drop got %b want 0", obs_ti);
    end
  endtask

  task automatic test_msip();
    logic [31:0] e, g;
    logic gv;
    sel = 1'b0;
    wr(CLINT_MSIP, 32'h1, 4'hF);
    checks++;
    if (obs_sw !== 1'b0) begin
      errors++;
      $display("FAIL msip_lag got %b want 0", obs_sw);
    end
    @(negedge clk);
    checks++;
    if (obs_sw !== 1'b1) begin
      errors++;
      $display("FAIL msip_set got %b want 1", obs_sw);
    end
    wr(CLINT_MSIP, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (obs_sw !== 1'b0) begin
      errors++;
      $display("FAIL msip_clr got %b want 0", obs_sw);
    end
    wr(CLINT_MSIP, 32'hFFFF_FFFF, 4'hF);
    rd(CLINT_MSIP, e, g, gv);
    checks++;
    if (g !== 32'h1 || e !== 32'h1) begin
      errors++;
      $display("FAIL msip_read got %h want 00000001", g);
    end
  endtask

  task automatic test_carry();
    logic [31:0] e, g;
    logic gv;
    sel = 1'b0;
    wr(CLINT_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    wr(CLINT_MTIME_HI, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    rd(CLINT_MTIME_LO, e, g, gv);
    checks++;
    if (g !== 32'h0) begin
      errors++;
      $display("FAIL carry_lo got %h want 0", g);
    end
    rd(CLINT_MTIME_HI, e, g, gv);
    checks++;
    if (g !== 32'h1) begin
      errors++;
      $display("FAIL carry_hi got %h want 1", g);
    end
    wr(CLINT_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr(CLINT_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd(CLINT_MTIME_LO, e, g, gv);
    checks++;
    if (g !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_pre got %h want ffffffff", g);
    end
    rd(CLINT_MTIME_HI, e, g, gv);
    checks++;
    if (g !== 32'h0) begin
      errors++;
      $display("FAIL wrap_hi got %h want 0", g);
    end
    rd(CLINT_MTIME_LO, e, g, gv);
    checks++;
    if (g !== 32'h1) begin
      errors++;
      $display("FAIL wrap_lo got %h want 1", g);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] e, g, first;
    logic gv;
    bit aligned;
    sel = 1'b1;
    do_reset();
    first = '0;
    for (int i = 0; i < 17; i++) begin
      rd(CLINT_MTIME_LO, e, g, gv);
      if (i == 0) first = g;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL div4_read got %h want %h", g, e);
      end
    end
    checks++;
    if (g - first !== 32'd4) begin
      errors++;
      $display("FAIL div4_rate got %0d want 4", g - first);
    end
    aligned = 0;
    for (int i = 0; i < 8 && !aligned; i++) begin
      if ((m_k[1] % 4) == 3) aligned = 1;
      else @(negedge clk);
    end
    wr(CLINT_MTIME_LO, 32'h100, 4'hF);
    rd(CLINT_MTIME_LO, e, g, gv);
    checks++;
    if (!aligned || g !== 32'h100) begin
      errors++;
      $display("FAIL div4_wr_tick got %h want 00000100", g);
    end
    sel = 1'b0;
  endtask

  task automatic test_byteen();
    logic [31:0] e, g;
    logic gv;
    sel = 1'b0;
    do_reset();
    wr(CLINT_MTIMECMP_LO, 32'hAABB_CCDD, 4'b0010);
    checks++;
    if (obs_rv !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got %b want 0", obs_rv);
    end
    rd(CLINT_MTIMECMP_LO, e, g, gv);
    checks++;
    if (g !== 32'hFFFF_CCFF) begin
      errors++;
      $display("FAIL byteen got %h want ffffccff", g);
    end
    rd(16'h1000, e, g, gv);
    checks++;
    if (g !== 32'h0 || gv !== 1'b1) begin
      errors++;
      $display("FAIL unmapped got %h/%b want 0/1", g, gv);
    end
  endtask

  task automatic test_random();
    logic [31:0] e, g, d;
    logic gv, r, w;
    logic [15:0] a;
    int pick;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sel  = ($urandom_range(0, 3) == 0);
      pick = $urandom_range(0, 6);
      case (pick)
        0: a = CLINT_MSIP;
        1: a = CLINT_MTIMECMP_LO;
        2: a = CLINT_MTIMECMP_HI;
        3: a = CLINT_MTIME_LO;
        4: a = CLINT_MTIME_HI;
        5: a = 16'h1000;
        default: a = 16'($urandom);
      endcase
      a = a | 16'($urandom_range(0, 3));
      r = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 2) == 0;
      d = $urandom;
      if ((pick == 2 || pick == 4) && $urandom_range(0, 3) != 0)
        d = 32'($urandom_range(0, 1));
      bus_op(r, w, a, d, 4'($urandom), e, g, gv);
      checks++;
      if (gv !== r || (r && g !== e)) begin
        errors++;
        $display("FAIL rand_read a=%h got %h/%b want %h/%b",
                 a, g, gv, e, r);
      end
      checks++;
      if (obs_ti !== m_ti[sel] || obs_sw !== m_sw[sel]) begin
        errors++;
        $display("FAIL rand_irq got %b%b want %b%b",
                 obs_ti, obs_sw, m_ti[sel], m_sw[sel]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    b_read = 1'b1;
    b_addr = CLINT_MTIME_LO;
    rst = 1'b1;
    @(negedge clk);
    b_read = 1'b0;
    checks++;
    if (rv0 !== 1'b0 || rd0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got %b/%h want 0/0", rv0, rd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_timer_cmp();
    test_msip();
    test_carry();
    test_prescale();
    test_byteen();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
